mem_access_unit: RTL



---
 rtl/mem_access_unit_pkg.sv | 19 +
 rtl/mem_access_unit.sv | 114 +++++++++++
 2 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: command opcodes (also used by the
// CPU control unit) and the sequencer states.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_FILL  = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_FIN  = 2'b11
  } state_e;

endpackage

// File: rtl/mem_access_unit.sv
// CPU-side initiator for data_memory: accepts byte load/store/fill bursts over a
// valid/ready command port and streams load bytes back over a valid/ready response.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [LEN_W:0] ONE_BEAT = (LEN_W + 1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LEN_W:0]    beats_q;
  logic              accept;
  logic              rd_fire;

  assign accept = req_valid && (state_q == S_IDLE);
  // A read is issued only while beats remain and the response slot is free or draining,
  // so a stalled consumer never loses a byte.
  assign rd_fire = (state_q == S_RD) && (beats_q != '0) && (!rsp_valid || rsp_ready);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first; a missed branch would
  // otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          unique case (op_e'(req_op))
            OP_LOAD:           state_d = S_RD;
            OP_STORE, OP_FILL: state_d = S_WR;
            OP_NOP:            state_d = S_FIN;
            default:           state_d = S_IDLE;
          endcase
        end
      end
      S_WR:    if (beats_q == ONE_BEAT) state_d = S_FIN;
      S_RD:    if ((beats_q == '0) && rsp_valid && rsp_ready) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state_q == S_IDLE);
    busy           = (state_q != S_IDLE);
    done           = (state_q == S_FIN);
    mem_write      = (state_q == S_WR);
    mem_read       = rd_fire;
    mem_address    = addr_q;
    mem_write_data = wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      beats_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        unique case (op_e'(req_op))
          OP_STORE:         beats_q <= ONE_BEAT;
          OP_LOAD, OP_FILL: beats_q <= {1'b0, req_len} + ONE_BEAT;
          default:          beats_q <= '0;
        endcase
      end else if ((state_q == S_WR) || rd_fire) begin
        // Address wraps modulo 2^ADDR_W, so bursts roll over silently.
        addr_q  <= addr_q + ADDR_W'(1);
        beats_q <= beats_q - ONE_BEAT;
      end

      if (rd_fire) begin
        rsp_rdata <= mem_read_data;
        rsp_valid <= 1'b1;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
